// File: rtl/bram_read_arbiter.sv
// Round-robin arbiter sharing one BRAM read port among N_PORTS requesters.
// Port 0 is the host, which can lock out the others; contention is counted.
module bram_read_arbiter #(
  parameter int unsigned N_PORTS    = 4,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned REG_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_PORTS-1:0]            req_valid,
  input  logic [N_PORTS*ADDR_WIDTH-1:0] req_addr,
  output logic [N_PORTS-1:0]            req_ready,
  output logic [N_PORTS-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_data,
  input  logic                          host_lock,
  input  logic                          clr_stats,
  output logic [REG_WIDTH-1:0]          contention_cc,
  output logic [ADDR_WIDTH-1:0]         mem_r_addr,
  output logic                          mem_r_valid,
  input  logic [DATA_WIDTH-1:0]         mem_r_data
);

  localparam int unsigned        IDX_W     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [N_PORTS-1:0] PORT0     = N_PORTS'(1);
  localparam logic [IDX_W-1:0]   LAST_PORT = IDX_W'(N_PORTS - 1);

  logic [N_PORTS-1:0]   elig_c;
  logic                 grant_c;
  logic [IDX_W-1:0]     gidx_c;
  logic [IDX_W-1:0]     cand_c;
  logic                 multi_c;

  logic [IDX_W-1:0]     last_q, last_d;
  logic                 rsp_pending_q, rsp_pending_d;
  logic [IDX_W-1:0]     rsp_port_q, rsp_port_d;
  logic [REG_WIDTH-1:0] cnt_q, cnt_d;

  assign elig_c  = host_lock ? (req_valid & PORT0) : req_valid;
  assign multi_c = ($countones(elig_c) >= 2);

  // First eligible port after the last winner, wrapping.
  always_comb begin
    grant_c = 1'b0;
    gidx_c  = '0;
    cand_c  = '0;
    for (int unsigned k = 1; k <= N_PORTS; k++) begin
      cand_c = IDX_W'((32'(last_q) + k) % N_PORTS);
      if (!grant_c && elig_c[cand_c]) begin
        grant_c = 1'b1;
        gidx_c  = cand_c;
      end
    end
  end

  always_comb begin
    last_d        = last_q;
    rsp_pending_d = grant_c;
    rsp_port_d    = gidx_c;
    cnt_d         = cnt_q;
    if (grant_c) begin
      last_d = gidx_c;
    end
    if (clr_stats) begin
      cnt_d = '0;
    end else if (multi_c && (cnt_q != '1)) begin
      cnt_d = cnt_q + REG_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q        <= LAST_PORT;
      rsp_pending_q <= 1'b0;
      rsp_port_q    <= '0;
      cnt_q         <= '0;
    end else begin
      last_q        <= last_d;
      rsp_pending_q <= rsp_pending_d;
      rsp_port_q    <= rsp_port_d;
      cnt_q         <= cnt_d;
    end
  end

  // Grant side is same-cycle; response side follows the BRAM's one-cycle latency.
  assign req_ready     = grant_c ? (PORT0 << gidx_c) : '0;
  assign mem_r_valid   = grant_c;
  assign mem_r_addr    = grant_c ? req_addr[32'(gidx_c)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign resp_valid    = rsp_pending_q ? (PORT0 << rsp_port_q) : '0;
  assign resp_data     = rsp_pending_q ? mem_r_data : '0;
  assign contention_cc = cnt_q;

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Directed and randomized checks of bram_read_arbiter against a behavioural model.
// A second instance with a 3-bit counter exercises saturation within a short run.
module tb_bram_read_arbiter;

  localparam int NP = 4;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [35:0] req_addr;
  logic        host_lock;
  logic        clr_stats;
  logic [63:0] mem_r_data;

  logic [3:0]  req_ready, resp_valid;
  logic [63:0] resp_data;
  logic [31:0] contention_cc;
  logic [8:0]  mem_r_addr;
  logic        mem_r_valid;

  logic [3:0]  s_req_ready, s_resp_valid;
  logic [63:0] s_resp_data;
  logic [2:0]  s_cc;
  logic [8:0]  s_mem_r_addr;
  logic        s_mem_r_valid;

  logic [63:0] mem [512];
  logic [8:0]  addr [4];

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int          m_last;
  bit          m_pend;
  int          m_rport;
  logic [63:0] m_rdata;
  longint      m_cnt, m_cnt_s;
  int          last_g;

  bram_read_arbiter #(.N_PORTS(4), .ADDR_WIDTH(9), .DATA_WIDTH(64), .REG_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .host_lock(host_lock), .clr_stats(clr_stats), .contention_cc(contention_cc),
    .mem_r_addr(mem_r_addr), .mem_r_valid(mem_r_valid), .mem_r_data(mem_r_data)
  );

  bram_read_arbiter #(.N_PORTS(4), .ADDR_WIDTH(9), .DATA_WIDTH(64), .REG_WIDTH(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(s_req_ready), .resp_valid(s_resp_valid), .resp_data(s_resp_data),
    .host_lock(host_lock), .clr_stats(clr_stats), .contention_cc(s_cc),
    .mem_r_addr(s_mem_r_addr), .mem_r_valid(s_mem_r_valid), .mem_r_data(mem_r_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // BRAM with one-cycle read latency
  initial mem_r_data = '0;
  always @(posedge clk) begin
    if (mem_r_valid) mem_r_data <= mem[mem_r_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Winner: eligible port at the smallest rotational distance past the last winner.
  function automatic int model_grant(input logic [3:0] e, input int last);
    int best = -1;
    int best_d = NP;
    for (int p = 0; p < NP; p++) begin
      int d = (p - last - 1 + NP) % NP;
      if (e[p] && d < best_d) begin
        best = p;
        best_d = d;
      end
    end
    return best;
  endfunction

  function automatic longint sat_inc(input longint v, input int width);
    longint mx = (64'sd1 <<< width) - 1;
    return (v + 1 > mx) ? mx : v + 1;
  endfunction

  task automatic model_reset();
    m_last = NP - 1; m_pend = 0; m_rport = 0; m_rdata = '0;
    m_cnt = 0; m_cnt_s = 0; last_g = -1;
  endtask

  task automatic cycle(input logic [3:0] v, input logic lk, input logic cl);
    logic [3:0] e;
    logic [3:0] exp_ready;
    int g;
    @(negedge clk);
    req_valid = v; host_lock = lk; clr_stats = cl;
    req_addr = {addr[3], addr[2], addr[1], addr[0]};
    #1;
    e = lk ? (v & 4'b0001) : v;
    g = model_grant(e, m_last);
    exp_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    chk("req_ready", req_ready, exp_ready);
    chk("sat_req_ready", s_req_ready, exp_ready);
    chk("mem_r_valid", mem_r_valid, (g >= 0));
    chk("mem_r_addr", mem_r_addr, (g >= 0) ? addr[g] : 9'd0);
    chk("resp_valid", resp_valid, m_pend ? (4'b0001 << m_rport) : 4'b0000);
    chk("resp_data", resp_data, m_pend ? m_rdata : 64'd0);
    chk("contention_cc", contention_cc, m_cnt);
    chk("sat_contention_cc", s_cc, m_cnt_s);
    if (cl) begin
      m_cnt = 0; m_cnt_s = 0;
    end else if ($countones(e) >= 2) begin
      m_cnt = sat_inc(m_cnt, 32); m_cnt_s = sat_inc(m_cnt_s, 3);
    end
    m_pend = (g >= 0);
    if (g >= 0) begin
      m_rport = g; m_last = g; m_rdata = mem[addr[g]];
    end
    last_g = g;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; host_lock = 1'b0; clr_stats = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 4'b0);
    chk("rst_resp_valid", resp_valid, 4'b0);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_mem_r_valid", mem_r_valid, 1'b0);
    chk("rst_mem_r_addr", mem_r_addr, 9'd0);
    chk("rst_contention_cc", contention_cc, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] hold;
    rst_n = 1'b0; req_valid = '0; req_addr = '0; host_lock = 1'b0; clr_stats = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = {$urandom, $urandom};
    mem[9'h015] = 64'hDEADBEEF_00000015;
    for (int i = 0; i < NP; i++) addr[i] = 9'(i * 37 + 5);
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Single request from port 2
    addr[2] = 9'h015;
    cycle(4'b0100, 1'b0, 1'b0);
    chk("single_ready", req_ready, 4'b0100);
    cycle(4'b0000, 1'b0, 1'b0);
    chk("single_resp_valid", resp_valid, 4'b0100);
    chk("single_resp_data", resp_data, 64'hDEADBEEF_00000015);
    chk("single_cc", contention_cc, 32'd0);

    // Full contention, then saturation and clear on the narrow counter
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(4'b1111, 1'b0, 1'b0);
      chk("rr_order", req_ready, 4'b0001 << (i % 4));
    end
    cycle(4'b0000, 1'b0, 1'b0);
    chk("full_cc", contention_cc, 32'd8);
    chk("sat_cc_hold", s_cc, 3'd7);
    cycle(4'b1111, 1'b0, 1'b1);
    cycle(4'b0000, 1'b0, 1'b0);
    chk("clr_cc", contention_cc, 32'd0);
    chk("clr_sat_cc", s_cc, 3'd0);

    // Host lock
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1001, 1'b1, 1'b0);
      chk("lock_ready", req_ready, 4'b0001);
    end
    cycle(4'b1001, 1'b0, 1'b0);
    chk("unlock_ready", req_ready, 4'b1000);

    // Sparse alternating requests
    cycle(4'b0010, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0);
    cycle(4'b1000, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0);
    cycle(4'b0010, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0);
    chk("sparse_idle_data", resp_data, 64'd0);

    // Reset while a response to port 1 is in flight
    cycle(4'b0010, 1'b0, 1'b0);
    chk("mid_grant", req_ready, 4'b0010);
    @(posedge clk);
    #1;
    rst_n = 1'b0; req_valid = '0;
    model_reset();
    @(negedge clk);
    #1;
    chk("mid_resp_valid", resp_valid, 4'b0);
    chk("mid_resp_data", resp_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'b1111, 1'b0, 1'b0);
    chk("mid_restart", req_ready, 4'b0001);

    // Randomized traffic; requesters hold until granted
    do_reset();
    hold = '0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (!hold[p] && ($urandom_range(1, 0) == 1)) begin
          hold[p] = 1'b1;
          addr[p] = 9'($urandom);
        end
      end
      cycle(hold, ($urandom_range(7, 0) == 0), ($urandom_range(15, 0) == 0));
      if (last_g >= 0) hold[last_g] = 1'b0;
    end
    cycle(4'b0000, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
